// File: rtl/conv_output_collector_pkg.sv
// conv_output_collector_pkg: output-map geometry helpers and bank state type
package conv_output_collector_pkg;

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_DRAINING
   } bank_state_t;

   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   function automatic int out_size(input int image, input int filter, input int stride);
      return (image - filter) / stride + 1;
   endfunction

   function automatic int map_words(input int image, input int filter, input int stride);
      return out_size(image, filter, stride) * out_size(image, filter, stride);
   endfunction

endpackage

// File: rtl/collector_bank_ram.sv
// collector_bank_ram: two-bank simple dual-port storage, bank selected by address MSB
module collector_bank_ram
   import conv_output_collector_pkg::*;
#(
   parameter int WORDS = 36,
   parameter int AW    = 6,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW:0]   wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW:0]   rd_addr,
   output logic [DW-1:0] rd_data
);
   localparam int DEPTH = 2 * WORDS;
   localparam int IW    = clog2_min1(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_data_q;

   function automatic logic [IW-1:0] row(input logic [AW:0] a);
      return a[AW] ? IW'(WORDS) + IW'(a[AW-1:0]) : IW'(a[AW-1:0]);
   endfunction

   // single write port and registered read port on independent addresses
   always_ff @(posedge clk) begin
      if (wr_en) mem[row(wr_addr)] <= wr_data;
      if (rd_en) rd_data_q <= mem[row(rd_addr)];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/conv_output_collector.sv
// conv_output_collector: ping-pong collector of window results with bubble-free streaming readback
module conv_output_collector
   import conv_output_collector_pkg::*;
#(
   parameter int FILTER_SIZE = 3,
   parameter int IMAGE_SIZE  = 8,
   parameter int STRIDE      = 1,
   parameter int DATA_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  frame_done,
   output logic                  overflow
);
   localparam int            MAP_WORDS = map_words(IMAGE_SIZE, FILTER_SIZE, STRIDE);
   localparam int            AW        = clog2_min1(MAP_WORDS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(MAP_WORDS - 1);

   bank_state_t           st_q [2];
   bank_state_t           st_d [2];
   logic                  fill_bank_q, fill_bank_d, drain_bank_q, drain_bank_d;
   logic [AW-1:0]         wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic                  rd_all_q, rd_all_d, rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
   logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic                  sk_valid_q, sk_valid_d, sk_last_q, sk_last_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d, sk_data_q, sk_data_d, rd_data;
   logic                  frame_done_q, frame_done_d, overflow_q, overflow_d;
   logic                  wr_en, rd_en, pop, fill_open, drain_want;
   logic [1:0]            occ;

   collector_bank_ram #(
      .WORDS(MAP_WORDS),
      .AW   (AW),
      .DW   (DATA_WIDTH)
   ) u_ram (
      .clk    (clk),
      .wr_en  (wr_en),
      .wr_addr({fill_bank_q, wr_addr_q}),
      .wr_data(in_data),
      .rd_en  (rd_en),
      .rd_addr({drain_bank_q, rd_addr_q}),
      .rd_data(rd_data)
   );

   // fill side, read issue with credit limit of two words past the RAM, and output/skid stage
   always_comb begin
      st_d         = st_q;
      fill_bank_d  = fill_bank_q;
      drain_bank_d = drain_bank_q;
      wr_addr_d    = wr_addr_q;
      rd_addr_d    = rd_addr_q;
      rd_all_d     = rd_all_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_data_d   = out_data_q;
      sk_valid_d   = sk_valid_q;
      sk_last_d    = sk_last_q;
      sk_data_d    = sk_data_q;
      pop          = out_valid_q & out_ready;
      fill_open    = st_q[fill_bank_q] == BANK_EMPTY || st_q[fill_bank_q] == BANK_FILLING;
      wr_en        = in_valid & fill_open;
      overflow_d   = overflow_q | (in_valid & ~fill_open);
      frame_done_d = wr_en && wr_addr_q == LAST_ADDR;
      if (wr_en) begin
         st_d[fill_bank_q] = frame_done_d ? BANK_FULL : BANK_FILLING;
         wr_addr_d         = frame_done_d ? '0 : wr_addr_q + AW'(1);
         fill_bank_d       = fill_bank_q ^ frame_done_d;
      end
      occ        = 2'(out_valid_q) + 2'(sk_valid_q) + 2'(rd_vld_q);
      drain_want = st_q[drain_bank_q] == BANK_FULL ||
                   (st_q[drain_bank_q] == BANK_DRAINING && !rd_all_q);
      rd_en      = drain_want && (occ - 2'(pop)) < 2'd2;
      rd_vld_d   = rd_en;
      rd_last_d  = rd_en && rd_addr_q == LAST_ADDR;
      if (rd_en) begin
         st_d[drain_bank_q] = BANK_DRAINING;
         rd_addr_d          = rd_last_d ? '0 : rd_addr_q + AW'(1);
         rd_all_d           = rd_last_d;
      end
      if (!out_valid_q || pop) begin
         out_valid_d = sk_valid_q | rd_vld_q;
         out_data_d  = sk_valid_q ? sk_data_q : rd_vld_q ? rd_data : out_data_q;
         out_last_d  = sk_valid_q ? sk_last_q : rd_last_q;
         sk_valid_d  = sk_valid_q & rd_vld_q;
         sk_data_d   = (sk_valid_q & rd_vld_q) ? rd_data : sk_data_q;
         sk_last_d   = sk_valid_q & rd_last_q;
      end else if (rd_vld_q) begin
         sk_valid_d = 1'b1;
         sk_data_d  = rd_data;
         sk_last_d  = rd_last_q;
      end
      if (pop && out_last_q) begin
         st_d[drain_bank_q] = BANK_EMPTY;
         drain_bank_d       = ~drain_bank_q;
         rd_all_d           = 1'b0;
      end
   end

   // state registers, all cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q         <= '{BANK_EMPTY, BANK_EMPTY};
         fill_bank_q  <= 1'b0;
         drain_bank_q <= 1'b0;
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
         rd_all_q     <= 1'b0;
         rd_vld_q     <= 1'b0;
         rd_last_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
         sk_valid_q   <= 1'b0;
         sk_last_q    <= 1'b0;
         sk_data_q    <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         st_q         <= st_d;
         fill_bank_q  <= fill_bank_d;
         drain_bank_q <= drain_bank_d;
         wr_addr_q    <= wr_addr_d;
         rd_addr_q    <= rd_addr_d;
         rd_all_q     <= rd_all_d;
         rd_vld_q     <= rd_vld_d;
         rd_last_q    <= rd_last_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
         sk_valid_q   <= sk_valid_d;
         sk_last_q    <= sk_last_d;
         sk_data_q    <= sk_data_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;

endmodule

// File: doc/conv_output_collector.md
CONV_OUTPUT_COLLECTOR -- requirements
Module: conv_output_collector

Interface
REQ-001 SHALL have parameter FILTER_SIZE, default 3, meaning convolution window edge in pixels.
REQ-002 SHALL have parameter IMAGE_SIZE, default 8, meaning input image edge in pixels.
REQ-003 SHALL have parameter STRIDE, default 1, meaning window step in pixels.
REQ-004 SHALL have parameter DATA_WIDTH, default 16, meaning result word width.
REQ-005 SHALL have port clk  input  1  meaning single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  meaning in_data carries one window result this cycle; no backpressure.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  meaning window result, raster order.
REQ-009 SHALL have port out_valid  output  1  meaning out_data holds a stored result.
REQ-010 SHALL have port out_ready  input  1  meaning downstream accepts out_data this cycle.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  meaning result read back, raster order.
REQ-012 SHALL have port out_last  output  1  meaning out_data is the final word of a feature map.
REQ-013 SHALL have port frame_done  output  1  meaning one-cycle pulse when a bank completes filling.
REQ-014 SHALL have port overflow  output  1  meaning sticky flag, an input was dropped.

Function
REQ-015 SHALL define OUT_SIZE = (IMAGE_SIZE-FILTER_SIZE)/STRIDE+1 and MAP_WORDS = OUT_SIZE*OUT_SIZE; all counters sized ceil(log2(MAP_WORDS)), minimum 1 bit.
REQ-016 SHALL hold two banks (A, B) of MAP_WORDS words each; fill and drain operate on opposite banks concurrently.
REQ-017 SHALL track each bank as EMPTY, FILLING, FULL or DRAINING.
REQ-018 Fill: on in_valid with fill bank EMPTY/FILLING, SHALL write in_data at wr_addr and increment wr_addr; bank becomes FILLING.
REQ-019 On the write at wr_addr = MAP_WORDS-1, SHALL mark bank FULL, reset wr_addr to 0, toggle fill bank, pulse frame_done the following cycle.
REQ-020 If in_valid arrives while the fill bank is FULL or DRAINING, SHALL drop the word, leave wr_addr unchanged, set overflow.
REQ-021 Drain: when drain bank is FULL and output stage empty, SHALL issue a read at rd_addr 0 and mark bank DRAINING; out_valid asserts 2 cycles after the bank became FULL.
REQ-022 SHALL hold out_data, out_valid, out_last stable while out_valid=1 and out_ready=0.
REQ-023 On out_valid&out_ready, SHALL present the next word on the next cycle with no bubbles (prefetch/skid), sustaining one word per cycle under continuous out_ready.
REQ-024 SHALL assert out_last with word MAP_WORDS-1; on its acceptance, drain bank becomes EMPTY, rd_addr returns to 0, drain bank toggles.
REQ-025 Simultaneous fill-complete on one bank and drain-complete on the other in the same cycle SHALL both take effect; no word lost or duplicated.
REQ-026 Write and read SHALL never target the same bank in the same cycle.
REQ-027 MAP_WORDS = 1 SHALL work: every input completes a bank and every output has out_last=1.

Reset
REQ-028 rst_n low SHALL immediately clear: both banks EMPTY, fill and drain bank = A, wr_addr = rd_addr = 0, out_valid = 0, out_last = 0, frame_done = 0, overflow = 0; out_data = 0.
REQ-029 Reset mid-frame SHALL discard partial and full banks; bank contents need not be cleared.
REQ-030 Only reset SHALL clear overflow.

Structure
REQ-031 OUT_SIZE/MAP_WORDS derivation and the log2 width function SHALL live in the shared constants header used by the pixel buffer blocks.
REQ-032 Storage SHALL be one sub-module, collector_bank_ram: simple dual-port, 1 write port, 1 synchronous-read port, depth 2*MAP_WORDS, bank select as address MSB.

Verification
REQ-033 IMAGE_SIZE=8, FILTER_SIZE=3, STRIDE=1, 36 writes of 0..35, out_ready=1 -> frame_done once, out_data 0..35 consecutive cycles, out_last on 35.
REQ-034 STRIDE=2 (MAP_WORDS=9), out_ready toggling 1/0 -> 9 words 0..8 in order, each held stable while out_ready=0.
REQ-035 Two maps back-to-back (72 writes), out_ready=1 -> second map fills bank B during drain of A, 72 ordered outputs, overflow=0.
REQ-036 out_ready=0, 3 maps written (MAP_WORDS=9) -> first 18 stored, 27th..., third map dropped, overflow=1; after release exactly 18 words out.
REQ-037 rst_n low after 20 of 36 writes -> all outputs at reset values; next 36 writes yield map restarting at address 0.
